// File: rtl/threshold_detector_pkg.sv
// threshold_detector_pkg
//   Shared definitions for the per-channel sample stages.
//   - SAMPLE_W_DEF / CNT_W_DEF : default sample and counter widths
//   - td_state_e               : detector FSM state encoding
//   - sat_abs()                : saturating magnitude of a sign-extended sample
package threshold_detector_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int CNT_W_DEF    = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_QUALIFY = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_HOLDOFF = 3'd4
  } td_state_e;

  // The caller sign-extends its sample to 32 bits and passes the largest
  // positive value of its own width as lim, so the most negative input
  // (whose true magnitude does not fit) clamps to lim. Works for widths up to 32.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x,
                                          input logic [31:0] lim);
    logic [31:0] m;
    m = x[31] ? 32'(-x) : 32'(x);
    return (m > lim) ? lim : m;
  endfunction

endpackage

// File: rtl/threshold_detector_if.sv
// threshold_detector_if
//   Sample stream into the detector and event outputs back to the timer stage.
//   sample_in/sample_valid : signed sample and its qualifier
//   detect                 : level, high while an event is active
//   peak_value/peak_valid  : peak magnitude of the last completed event, update pulse
//   event_count            : completed events, saturating
//   modport master = sample source / event consumer, slave = detector
interface threshold_detector_if
  import threshold_detector_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) ();

  logic signed [SAMPLE_W-1:0] sample_in;
  logic                       sample_valid;
  logic                       detect;
  logic [SAMPLE_W-1:0]        peak_value;
  logic                       peak_valid;
  logic [CNT_W-1:0]           event_count;

  modport master (
    output sample_in, sample_valid,
    input  detect, peak_value, peak_valid, event_count
  );

  modport slave (
    input  sample_in, sample_valid,
    output detect, peak_value, peak_valid, event_count
  );

endinterface

// File: rtl/threshold_detector_abs_mag_stage.sv
// abs_mag_stage
//   Registered saturating magnitude of a signed sample plus delayed valid.
//   clk, rst  : clock, synchronous active-high reset
//   i_sample  : signed sample       i_valid : sample qualifier
//   o_mag     : |i_sample|, most negative value clamps to max positive
//   o_mag_v   : i_valid delayed one cycle
module abs_mag_stage
  import threshold_detector_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic                       i_valid,
  output logic [SAMPLE_W-1:0]        o_mag,
  output logic                       o_mag_v
);

  localparam logic [31:0] MAG_MAX = 32'((64'd1 << (SAMPLE_W - 1)) - 64'd1);

  logic [SAMPLE_W-1:0] r_mag;
  logic                r_mag_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag   <= '0;
      r_mag_v <= 1'b0;
    end else begin
      r_mag   <= SAMPLE_W'(sat_abs(32'(i_sample), MAG_MAX));
      r_mag_v <= i_valid;
    end
  end

  assign o_mag   = r_mag;
  assign o_mag_v = r_mag_v;

endmodule

// File: rtl/threshold_detector.sv
// threshold_detector
//   Qualifies threshold crossings of one channel's sample stream (hysteresis,
//   minimum run, dead time) and drives a clean registered detect level.
//   clk, rst   : clock, synchronous active-high reset
//   i_enable   : 1 = running, 0 = forced idle
//   i_thr_high : assert threshold (mag >= thr_high)
//   i_thr_low  : release threshold (mag < min(thr_low, thr_high))
//   i_min_run  : consecutive qualifying samples needed, 0 behaves as 1
//   i_holdoff  : dead time in clk cycles after release, 0 = rearm at once
//   bus        : sample stream in, detect/peak/event_count out
//
//   state   | meaning
//   IDLE    | disabled, waiting for enable
//   ARMED   | waiting for first sample at/above thr_high
//   QUALIFY | counting consecutive samples at/above thr_high
//   ACTIVE  | event in progress, detect high, tracking peak
//   HOLDOFF | dead time after release, samples ignored
module threshold_detector
  import threshold_detector_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_enable,
  input  logic [SAMPLE_W-1:0] i_thr_high,
  input  logic [SAMPLE_W-1:0] i_thr_low,
  input  logic [CNT_W-1:0]    i_min_run,
  input  logic [CNT_W-1:0]    i_holdoff,
  threshold_detector_if.slave bus
);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_ARMED   = ST_ARMED;
  localparam logic [2:0] S_QUALIFY = ST_QUALIFY;
  localparam logic [2:0] S_ACTIVE  = ST_ACTIVE;
  localparam logic [2:0] S_HOLDOFF = ST_HOLDOFF;

  logic [SAMPLE_W-1:0] w_mag;
  logic                w_mag_v;

  abs_mag_stage #(.SAMPLE_W(SAMPLE_W)) u_abs (
    .clk      (clk),
    .rst      (rst),
    .i_sample (bus.sample_in),
    .i_valid  (bus.sample_valid),
    .o_mag    (w_mag),
    .o_mag_v  (w_mag_v)
  );

  logic [2:0]          r_state;
  logic [CNT_W-1:0]    r_run;
  logic [CNT_W-1:0]    r_hold;
  logic [CNT_W-1:0]    r_count;
  logic [SAMPLE_W-1:0] r_peak;
  logic [SAMPLE_W-1:0] r_peak_value;
  logic                r_peak_valid;
  logic                r_detect;

  logic [SAMPLE_W-1:0] w_eff_low;
  logic [SAMPLE_W-1:0] w_peak_next;
  logic [CNT_W-1:0]    w_min_run;
  logic [CNT_W-1:0]    w_run_next;
  logic                w_hit;
  logic                w_miss;
  logic                w_release;

  // A low threshold above the high one would release on samples that just
  // asserted; clamp so hysteresis can never be inverted.
  assign w_eff_low   = (i_thr_low < i_thr_high) ? i_thr_low : i_thr_high;
  assign w_min_run   = (i_min_run == '0) ? CNT_W'(1) : i_min_run;
  assign w_run_next  = r_run + CNT_W'(1);
  assign w_hit       = w_mag_v && (w_mag >= i_thr_high);
  assign w_miss      = w_mag_v && (w_mag < i_thr_high);
  assign w_release   = w_mag_v && (w_mag < w_eff_low);
  assign w_peak_next = (w_mag > r_peak) ? w_mag : r_peak;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_run        <= '0;
      r_hold       <= '0;
      r_count      <= '0;
      r_peak       <= '0;
      r_peak_value <= '0;
      r_peak_valid <= 1'b0;
      r_detect     <= 1'b0;
    end else begin
      r_peak_valid <= 1'b0;
      if (!i_enable) begin
        r_state  <= S_IDLE;
        r_run    <= '0;
        r_hold   <= '0;
        r_peak   <= '0;
        r_detect <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_ARMED;
          S_ARMED: begin
            if (w_hit) begin
              r_peak <= w_mag;
              if (w_min_run == CNT_W'(1)) begin
                r_state  <= S_ACTIVE;
                r_detect <= 1'b1;
              end else begin
                r_state <= S_QUALIFY;
                r_run   <= CNT_W'(1);
              end
            end
          end
          S_QUALIFY: begin
            if (w_hit) begin
              r_peak <= w_peak_next;
              // >= so a live lowering of min_run mid-run cannot strand the count
              if (w_run_next >= w_min_run) begin
                r_state  <= S_ACTIVE;
                r_detect <= 1'b1;
                r_run    <= '0;
              end else begin
                r_run <= w_run_next;
              end
            end else if (w_miss) begin
              r_state <= S_ARMED;
              r_run   <= '0;
            end
          end
          S_ACTIVE: begin
            if (w_release) begin
              r_detect     <= 1'b0;
              r_peak_valid <= 1'b1;
              r_peak_value <= r_peak;
              if (r_count != '1) r_count <= r_count + CNT_W'(1);
              if (i_holdoff == '0) begin
                r_state <= S_ARMED;
              end else begin
                r_state <= S_HOLDOFF;
                r_hold  <= i_holdoff;
              end
            end else if (w_mag_v) begin
              r_peak <= w_peak_next;
            end
          end
          S_HOLDOFF: begin
            if (r_hold <= CNT_W'(1)) begin
              r_state <= S_ARMED;
              r_hold  <= '0;
            end else begin
              r_hold <= r_hold - CNT_W'(1);
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_detect <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.detect      = r_detect;
  assign bus.peak_value  = r_peak_value;
  assign bus.peak_valid  = r_peak_valid;
  assign bus.event_count = r_count;

endmodule

// File: tb/tb_threshold_detector.sv
module tb_threshold_detector;
  import threshold_detector_pkg::*;

  localparam int K_RISE = 1;
  localparam int K_DROP = 2;
  localparam int K_REL  = 3;

  typedef struct {
    int kind;
    int cyc;
    int peak;
    int cnt;
  } exp_t;

  // -1 in any field means "do not compare"
  typedef struct {
    int det;
    int pv;
    int peak;
    int cnt;
    int scnt;
    int spv;
    int pend;
  } stat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] thr_high = 16'd1000;
  logic [15:0] thr_low  = 16'd500;
  logic [15:0] min_run  = 16'd3;
  logic [15:0] holdoff  = 16'd10;

  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;
  int    sat_pv = 0;
  bit    prev_det = 1'b0;
  exp_t  q[$];
  stat_t sq[$];

  threshold_detector_if #(.SAMPLE_W(16), .CNT_W(16)) u_if ();
  threshold_detector_if #(.SAMPLE_W(16), .CNT_W(2))  u_sif ();

  assign u_sif.sample_in    = u_if.sample_in;
  assign u_sif.sample_valid = u_if.sample_valid;

  threshold_detector #(.SAMPLE_W(16), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_enable   (enable),
    .i_thr_high (thr_high),
    .i_thr_low  (thr_low),
    .i_min_run  (min_run),
    .i_holdoff  (holdoff),
    .bus        (u_if)
  );

  // narrow counter instance: event_count saturates after 3 events
  threshold_detector #(.SAMPLE_W(16), .CNT_W(2)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .i_enable   (enable),
    .i_thr_high (thr_high),
    .i_thr_low  (thr_low),
    .i_min_run  (2'd1),
    .i_holdoff  (2'd0),
    .bus        (u_sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void cmp(string name, int act, int exp);
    if (exp < 0) return;
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // monitor: classifies DUT output events and checks them against the queues
  always @(negedge clk) begin
    int    kind;
    exp_t  e;
    stat_t s;
    kind = 0;
    if (rst) sat_pv = 0;
    else if (u_sif.peak_valid) sat_pv++;
    if (!rst) begin
      if (u_if.peak_valid) kind = K_REL;
      else if (u_if.detect && !prev_det) kind = K_RISE;
      else if (!u_if.detect && prev_det) kind = K_DROP;
    end
    prev_det = u_if.detect;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      cmp("missed_event", 0, e.kind);
    end
    if (kind != 0) begin
      if (q.size() == 0) begin
        cmp("unexpected_event", kind, 0);
      end else begin
        e = q.pop_front();
        cmp("event_kind", kind, e.kind);
        cmp("event_cycle", cyc, e.cyc);
        if (e.kind == K_REL) begin
          cmp("release_detect", int'(u_if.detect), 0);
          cmp("peak_value", int'(u_if.peak_value), e.peak);
          cmp("event_count", int'(u_if.event_count), e.cnt);
        end
      end
    end
    while (sq.size() > 0) begin
      s = sq.pop_front();
      cmp("stat_detect", int'(u_if.detect), s.det);
      cmp("stat_peak_valid", int'(u_if.peak_valid), s.pv);
      cmp("stat_peak_value", int'(u_if.peak_value), s.peak);
      cmp("stat_event_count", int'(u_if.event_count), s.cnt);
      cmp("sat_event_count", int'(u_sif.event_count), s.scnt);
      cmp("sat_peak_pulses", sat_pv, s.spv);
      cmp("pending_events", q.size(), s.pend);
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
      u_if.sample_valid = 1'b0;
    end
  endtask

  task automatic smp(int v);
    @(posedge clk); #1;
    u_if.sample_in    = 16'(v);
    u_if.sample_valid = 1'b1;
  endtask

  function automatic void expect_ev(int kind, int dly, int peak = 0, int cnt = 0);
    q.push_back('{kind, cyc + dly, peak, cnt});
  endfunction

  function automatic void stat(int det, int pv, int peak, int cnt, int scnt, int spv, int pend);
    sq.push_back('{det, pv, peak, cnt, scnt, spv, pend});
  endfunction

  initial begin
    u_if.sample_in    = '0;
    u_if.sample_valid = 1'b0;
    idle(3);
    stat(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1; rst = 1'b0;
    idle(3);

    // T1: min_run=3 with a valid gap and a negative sample in the run
    smp(1200); idle(2); smp(-1300); smp(1100); expect_ev(K_RISE, 2);
    smp(400);  expect_ev(K_REL, 2, 1300, 1);
    idle(12);

    // T2: broken run, then a fresh run; T3: hysteresis band and active peak tracking
    smp(1200); smp(1200); smp(900);
    smp(1200); smp(1200); smp(1200); expect_ev(K_RISE, 2);
    smp(700); smp(1500); smp(700); smp(700);
    smp(499);  expect_ev(K_REL, 2, 1500, 2);
    idle(12);

    // T4: most negative sample saturates
    thr_high = 16'd32767; min_run = 16'd1;
    smp(-32768); expect_ev(K_RISE, 2);
    smp(0);      expect_ev(K_REL, 2, 32767, 3);
    idle(12);
    thr_high = 16'd1000;

    // T5: holdoff of 10 ignores samples, then rearm; holdoff=0 rearms at once
    smp(2000); expect_ev(K_RISE, 2);
    smp(100);  expect_ev(K_REL, 2, 2000, 4);
    repeat (11) smp(2000);
    expect_ev(K_RISE, 2);
    holdoff = 16'd0;
    smp(100);  expect_ev(K_REL, 2, 2000, 5);
    smp(2000); expect_ev(K_RISE, 2);
    smp(100);  expect_ev(K_REL, 2, 2000, 6);
    holdoff = 16'd10;
    idle(12);

    // T6a: enable dropped while active
    smp(2000); expect_ev(K_RISE, 2);
    idle(3);
    @(posedge clk); #1; enable = 1'b0; expect_ev(K_DROP, 1);
    idle(2);
    @(posedge clk); #1; enable = 1'b1;
    stat(0, -1, 2000, 6, -1, -1, -1);
    idle(2);
    smp(1100); expect_ev(K_RISE, 2);
    smp(0);    expect_ev(K_REL, 2, 1100, 7);
    idle(12);

    // T6b: thr_low above thr_high releases below thr_high
    thr_low = 16'd2000;
    smp(1500); expect_ev(K_RISE, 2);
    smp(1200);
    smp(999);  expect_ev(K_REL, 2, 1500, 8);
    idle(12);
    thr_low = 16'd500;

    // T6c: reset mid-qualify
    min_run = 16'd3;
    smp(1200); smp(1200);
    @(posedge clk); #1; rst = 1'b1; u_if.sample_valid = 1'b0;
    idle(2);
    stat(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1; rst = 1'b0;
    idle(2);
    smp(1200); smp(0);
    idle(2);

    // event_count saturation on the narrow instance
    min_run = 16'd1; holdoff = 16'd0;
    for (int k = 1; k <= 4; k++) begin
      smp(1200); expect_ev(K_RISE, 2);
      smp(0);    expect_ev(K_REL, 2, 1200, k);
      idle(2);
      stat(-1, -1, -1, -1, (k + 1 > 3) ? 3 : k + 1, -1, -1);
    end
    idle(3);
    stat(0, -1, -1, -1, 3, 5, 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
